enc_bundler_accum: RTL and testbench
====================================

// Module: enc_bundler_accum
// PURPOSE
//  Downstream of the binder pack: consumes NUM_IN shifted (bound) sparse HVs per accepted beat.
//  Accumulates per-bit popcounts over NUM_GROUPS beats, i.e. one full sample of features.
//  Thresholds the counts into one sparse bundled sample HV, presented on a valid/ready output.
//  Feeds the downstream class-similarity stage.
// PARAMETERS
//  HV_DIM      1024  hypervector width in bits
//  NUM_IN      16    HVs per beat (one binder pack, FEATURES_PER_CC/2)
//  NUM_GROUPS  32    beats per sample
//  CNT_W       $clog2(NUM_IN*NUM_GROUPS+1)  per-bit counter width (10 at defaults)
// PORTS
//  clk             in   1              system clock, all state on rising edge
//  nrst            in   1              asynchronous active-low reset
//  start_encoding  in   1              sample-start pulse; honoured only in IDLE
//  threshold       in   CNT_W          bit-set threshold; sampled on accepted start
//  in_valid        in   1              shifted_hv beat valid
//  in_ready        out  1              high exactly while state==ACCUM
//  shifted_hv      in   HV_DIM x NUM_IN  unpacked [0:NUM_IN-1] bound HVs from binder pack
//  out_valid       out  1              bundled_hv valid
//  out_ready       in   1              consumer accepts bundled_hv
//  bundled_hv      out  HV_DIM         thresholded sample HV
//  busy            out  1              state != IDLE
//  beat_cnt        out  $clog2(NUM_GROUPS+1)  beats accepted in current sample
// BEHAVIOUR
//  Reset (async, nrst=0):
//   - state=IDLE; all per-bit counters, beat_cnt, threshold register = 0.
//   - bundled_hv = 0; out_valid = in_ready = busy = 0.
//   - Applies immediately, in any state; a sample in progress is discarded, no partial output.
//  FSM IDLE -> ACCUM -> THRESH -> OUT -> IDLE:
//   - IDLE: start_encoding=1 -> clear all counters and beat_cnt, latch threshold, go ACCUM.
//     in_valid is ignored.
//   - ACCUM: beat accepted when in_valid=1 (in_ready=1 here).
//     Accepted beat: cnt[b] += popcount over i of shifted_hv[i][b], for every bit b.
//     Accepted beat: beat_cnt increments.
//     On acceptance of beat NUM_GROUPS: go THRESH. beat_cnt reads NUM_GROUPS in THRESH and OUT.
//     in_valid=0 stalls with no state change.
//   - THRESH (1 cycle): bundled_hv[b] <= (cnt[b] >= threshold_reg); go OUT.
//   - OUT: out_valid=1; bundled_hv held stable until out_ready=1 (handshake).
//     Handshake cycle: out_valid drops next cycle, go IDLE.
//     bundled_hv keeps its last value in IDLE.
//  start_encoding outside IDLE is ignored, including the OUT handshake cycle.
//   - Next sample needs a start_encoding in a later IDLE cycle.
//   - Minimum gap between outputs: NUM_GROUPS+3 cycles.
//  Latency: accepted final beat at cycle N -> THRESH at N+1 -> out_valid=1 at N+2.
//  Arithmetic: per-beat popcount is 0..NUM_IN, unsigned.
//   - Counter max NUM_IN*NUM_GROUPS fits CNT_W, so no overflow or saturation logic.
//  Threshold corners: threshold=0 -> bundled_hv all ones.
//   - threshold > NUM_IN*NUM_GROUPS -> bundled_hv all zeros.
//  Counter update, beat_cnt update and FSM transition happen in the same clk edge.
//  shifted_hv is not registered at input; the upstream binder pack drives it registered.
// TESTING
//  1 Reset: nrst=0 mid-ACCUM after 5 beats -> next cycle busy=0, in_ready=0, beat_cnt=0.
//    Next start yields counts from 0.
//  2 Basic: threshold=1, 32 beats; lane0 bit7 set once -> bundled_hv = 1<<7.
//    out_valid exactly 2 cycles after 32nd beat.
//  3 Threshold edge: bit3 set in all 16 lanes for 2 beats (cnt=32), bit4 cnt=31, threshold=32.
//    -> bit3=1, bit4=0.
//  4 Saturation bound: every bit set, all lanes, all 32 beats, threshold=512.
//    -> bundled_hv all ones; threshold=513 -> all zeros.
//  5 Stalls/backpressure: random in_valid gaps, out_ready low 10 cycles.
//    -> result equals gapless run; bundled_hv stable while out_valid=1 and out_ready=0.
//  6 Ignored start: start_encoding pulsed in ACCUM and in OUT handshake cycle.
//    -> no counter clear, returns IDLE; threshold change during ACCUM has no effect.

Source files
------------

// File: rtl/enc_bundler_accum_if.sv
// Stream bundle for the bundler: bound-HV beats in, thresholded sample HV out.
interface enc_bundler_accum_if #(
    parameter int HV_DIM = 1024,
    parameter int NUM_IN = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] shifted_hv [NUM_IN];
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] bundled_hv;

    modport master (
        output in_valid, shifted_hv, out_ready,
        input  in_ready, out_valid, bundled_hv
    );
    modport slave (
        input  in_valid, shifted_hv, out_ready,
        output in_ready, out_valid, bundled_hv
    );
endinterface

// File: rtl/enc_bundler_accum.sv
// Bundler: per-bit popcount accumulation over a full sample of beats, then
// thresholding into one sparse sample HV handed out on a valid/ready port.
module enc_bundler_bit #(
    parameter int NUM_IN = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clr,
    input  logic              add_en,
    input  logic              thr_en,
    input  logic [NUM_IN-1:0] bits,
    input  logic [CNT_W-1:0]  threshold,
    output logic              hv_bit
);
    logic [CNT_W-1:0] cnt_q, cnt_d, pop;
    logic             hv_q, hv_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_IN; i++) pop = pop + {{(CNT_W-1){1'b0}}, bits[i]};
        cnt_d = cnt_q;
        hv_d  = hv_q;
        if (clr)         cnt_d = '0;
        else if (add_en) cnt_d = cnt_q + pop;
        if (thr_en)      hv_d  = (cnt_q >= threshold);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            hv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hv_q  <= hv_d;
        end
    end

    assign hv_bit = hv_q;
endmodule

module enc_bundler_accum #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_IN     = 16,
    parameter int NUM_GROUPS = 32,
    parameter int CNT_W      = $clog2(NUM_IN*NUM_GROUPS+1),
    parameter int BEAT_W     = $clog2(NUM_GROUPS+1)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start_encoding,
    input  logic [CNT_W-1:0]    threshold,
    enc_bundler_accum_if.slave  bus,
    output logic                busy,
    output logic [BEAT_W-1:0]   beat_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_e;

    state_e                       state_q, state_d;
    logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]             thr_q, thr_d;
    logic                         clr, add_en, thr_en;
    logic [HV_DIM-1:0][NUM_IN-1:0] lane_bits;
    logic [HV_DIM-1:0]            hv;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        thr_d      = thr_q;
        clr        = 1'b0;
        add_en     = 1'b0;
        thr_en     = 1'b0;
        case (state_q)
            IDLE: if (start_encoding) begin
                clr        = 1'b1;
                beat_cnt_d = '0;
                thr_d      = threshold;
                state_d    = ACCUM;
            end
            ACCUM: if (bus.in_valid) begin
                add_en     = 1'b1;
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == BEAT_W'(NUM_GROUPS-1)) state_d = THRESH;
            end
            THRESH: begin
                thr_en  = 1'b1;
                state_d = OUT;
            end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            thr_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            thr_q      <= thr_d;
        end
    end

    // Transpose lanes so each bit slice sees its NUM_IN contributions together.
    always_comb begin
        lane_bits = '0;
        for (int b = 0; b < HV_DIM; b++)
            for (int i = 0; i < NUM_IN; i++)
                lane_bits[b][i] = bus.shifted_hv[i][b];
    end

    for (genvar b = 0; b < HV_DIM; b++) begin : g_bit
        enc_bundler_bit #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) u_bit (
            .clk       (clk),
            .nrst      (nrst),
            .clr       (clr),
            .add_en    (add_en),
            .thr_en    (thr_en),
            .bits      (lane_bits[b]),
            .threshold (thr_q),
            .hv_bit    (hv[b])
        );
    end

    assign bus.bundled_hv = hv;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.in_ready   = (state_q == ACCUM);
    assign busy           = (state_q != IDLE);
    assign beat_cnt       = beat_cnt_q;
endmodule

// File: tb/tb_enc_bundler_accum.sv
// Directed bench for enc_bundler_accum: reset, thresholds, stalls, ignored starts.
module tb_enc_bundler_accum;
    localparam int HV_DIM = 1024, NUM_IN = 16, NUM_GROUPS = 32, CNT_W = 10, BEAT_W = 6;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start_encoding = 1'b0;
    logic [CNT_W-1:0]  threshold = '0;
    logic              busy;
    logic [BEAT_W-1:0] beat_cnt;
    int                checks = 0;
    int                failures = 0;
    logic [HV_DIM-1:0] beat_mem [NUM_GROUPS][NUM_IN];
    logic [HV_DIM-1:0] exp_hv;
    bit                ok;

    enc_bundler_accum_if #(.HV_DIM(HV_DIM), .NUM_IN(NUM_IN)) bus ();

    enc_bundler_accum #(.HV_DIM(HV_DIM), .NUM_IN(NUM_IN), .NUM_GROUPS(NUM_GROUPS)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_encoding (start_encoding),
        .threshold      (threshold),
        .bus            (bus),
        .busy           (busy),
        .beat_cnt       (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int g = 0; g < NUM_GROUPS; g++)
            for (int i = 0; i < NUM_IN; i++) beat_mem[g][i] = '0;
    endtask

    task automatic start_sample(input logic [CNT_W-1:0] th);
        start_encoding = 1'b1;
        threshold      = th;
        step();
        start_encoding = 1'b0;
    endtask

    task automatic send_beat(input int g);
        for (int i = 0; i < NUM_IN; i++) bus.shifted_hv[i] = beat_mem[g][i];
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input bit gaps);
        for (int g = from; g <= to; g++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step();
            send_beat(g);
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    // Reference: count each bit across all lanes and beats, compare to threshold.
    task automatic model(input int th);
        int cnt;
        for (int b = 0; b < HV_DIM; b++) begin
            cnt = 0;
            for (int g = 0; g < NUM_GROUPS; g++)
                for (int i = 0; i < NUM_IN; i++) cnt += int'(beat_mem[g][i][b]);
            exp_hv[b] = (cnt >= th);
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks += 5;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        if (beat_cnt !== '0) begin failures++; $display("FAIL rst_beat_cnt got=%0d exp=0", beat_cnt); end
        if (bus.bundled_hv !== '0) begin failures++; $display("FAIL rst_bundled got=%h exp=0", bus.bundled_hv); end
        nrst = 1'b1;
        step();
        clear_mem();
        for (int g = 0; g < NUM_GROUPS; g++) beat_mem[g][0][0] = 1'b1;
        start_sample(10'd1);
        feed(0, 4, 1'b0);
        checks++;
        if (beat_cnt !== 6'd5) begin failures++; $display("FAIL mid_beat_cnt got=%0d exp=5", beat_cnt); end
        nrst = 1'b0;
        #2;
        step();
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
        if (beat_cnt !== '0) begin failures++; $display("FAIL midrst_beat_cnt got=%0d exp=0", beat_cnt); end
        nrst = 1'b1;
        step();
        clear_mem();
        beat_mem[3][2][9] = 1'b1;
        exp_hv = '0;
        exp_hv[9] = 1'b1;
        start_sample(10'd1);
        feed(0, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL postrst_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL postrst_hv got=%h exp=%h", bus.bundled_hv, exp_hv); end
        handshake();
    endtask

    task automatic test_basic();
        clear_mem();
        beat_mem[10][0][7] = 1'b1;
        exp_hv = '0;
        exp_hv[7] = 1'b1;
        start_sample(10'd1);
        feed(0, NUM_GROUPS-1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
        step();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", bus.out_valid); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL basic_hv got=%h exp=%h", bus.bundled_hv, exp_hv); end
        if (beat_cnt !== 6'd32) begin failures++; $display("FAIL basic_beat_cnt got=%0d exp=32", beat_cnt); end
        handshake();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.out_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL basic_hold got=%h exp=%h", bus.bundled_hv, exp_hv); end
    endtask

    task automatic test_threshold_edge();
        clear_mem();
        for (int i = 0; i < NUM_IN; i++) begin
            beat_mem[0][i][3] = 1'b1;
            beat_mem[1][i][3] = 1'b1;
            beat_mem[0][i][4] = 1'b1;
            if (i < NUM_IN-1) beat_mem[1][i][4] = 1'b1;
        end
        exp_hv = '0;
        exp_hv[3] = 1'b1;
        start_sample(10'd32);
        feed(0, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL edge_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL edge_hv got=%h exp=%h", bus.bundled_hv, exp_hv); end
        handshake();
    endtask

    task automatic test_saturation();
        for (int g = 0; g < NUM_GROUPS; g++)
            for (int i = 0; i < NUM_IN; i++) beat_mem[g][i] = '1;
        start_sample(10'd512);
        feed(0, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL sat512_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== {HV_DIM{1'b1}}) begin failures++; $display("FAIL sat512_hv got=%h exp=all ones", bus.bundled_hv); end
        handshake();
        start_sample(10'd513);
        feed(0, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL sat513_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== '0) begin failures++; $display("FAIL sat513_hv got=%h exp=0", bus.bundled_hv); end
        handshake();
        clear_mem();
        start_sample(10'd0);
        feed(0, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL thr0_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== {HV_DIM{1'b1}}) begin failures++; $display("FAIL thr0_hv got=%h exp=all ones", bus.bundled_hv); end
        handshake();
    endtask

    task automatic test_stalls();
        clear_mem();
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int i = 0; i < NUM_IN; i++) beat_mem[g][i][((g*16+i)*3) % HV_DIM] = 1'b1;
            beat_mem[g][0][g % 8] = 1'b1;
        end
        model(2);
        start_sample(10'd2);
        feed(0, NUM_GROUPS-1, 1'b1);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL stall_hv got=%h exp=%h", bus.bundled_hv, exp_hv); end
        for (int k = 0; k < 10; k++) begin
            step();
            checks += 2;
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, bus.out_valid); end
            if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", k, bus.bundled_hv, exp_hv); end
        end
        handshake();
    endtask

    task automatic test_ignored_start();
        clear_mem();
        beat_mem[0][0][100] = 1'b1;
        for (int i = 0; i < 4; i++) beat_mem[7][i][200] = 1'b1;
        beat_mem[31][15][1023] = 1'b1;
        model(1);
        start_sample(10'd1);
        feed(0, 4, 1'b0);
        start_encoding = 1'b1;
        threshold      = 10'd600;
        send_beat(5);
        start_encoding = 1'b0;
        checks += 2;
        if (beat_cnt !== 6'd6) begin failures++; $display("FAIL ign_beat_cnt got=%0d exp=6", beat_cnt); end
        if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
        feed(6, NUM_GROUPS-1, 1'b0);
        wait_valid(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL ign_timeout got=0 exp=1"); end
        if (bus.bundled_hv !== exp_hv) begin failures++; $display("FAIL ign_hv got=%h exp=%h", bus.bundled_hv, exp_hv); end
        start_encoding = 1'b1;
        handshake();
        start_encoding = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ign_out_idle got=%b exp=0", busy); end
        step();
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL ign_stay_idle got=%b exp=0", busy); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready got=%b exp=0", bus.in_ready); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) bus.shifted_hv[i] = '0;
        test_reset();
        test_basic();
        test_threshold_edge();
        test_saturation();
        test_stalls();
        test_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
